// File: rtl/div_pkg.sv
// Shared widths, FSM state encoding and constants for the non-restoring divider.
package div_pkg;

    localparam int DW = 20;
    localparam int VW = 16;
    localparam int PW = VW + 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_e;

    localparam logic [DW-1:0] DZ_QUOT = '1;

endpackage

// File: rtl/addsub18.sv
// Combinational W-bit add/subtract (y = a + b or a - b), split into a low half
// and a carry-selected high half to mirror the datapath adders.
module addsub18
    import div_pkg::*;
#(
    parameter int W = PW
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_y
);

    localparam int LW = W / 2;
    localparam int HW = W - LW;

    logic [W-1:0]  w_b;
    logic [LW:0]   w_lo;
    logic [HW-1:0] w_hi0;
    logic [HW-1:0] w_hi1;

    // Subtraction is a + ~b + 1, with the +1 entering as the low-half carry-in.
    assign w_b   = i_b ^ {W{i_sub}};
    assign w_lo  = {1'b0, i_a[LW-1:0]} + {1'b0, w_b[LW-1:0]} + {{LW{1'b0}}, i_sub};
    assign w_hi0 = i_a[W-1:LW] + w_b[W-1:LW];
    assign w_hi1 = i_a[W-1:LW] + w_b[W-1:LW] + HW'(1);
    assign o_y   = {(w_lo[LW] ? w_hi1 : w_hi0), w_lo[LW-1:0]};

endmodule

// File: rtl/nr_divider.sv
// Sequential unsigned non-restoring divider: one quotient bit per clock through a
// single shared add/subtract unit, with valid/ready handshakes on both sides.
module nr_divider #(
    parameter int DW = 20,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    import div_pkg::*;

    localparam int PW = VW + 2;
    localparam int CW = $clog2(DW);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [PW-1:0] r_p;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_div_zero;

    logic          w_accept;
    logic [PW-1:0] w_p_shift;
    logic [PW-1:0] w_add_a;
    logic          w_add_sub;
    logic [PW-1:0] w_sum;

    assign w_accept  = (r_state == IDLE) && in_valid;
    assign w_p_shift = {r_p[PW-2:0], r_q[DW-1]};

    // RUN steps the shifted remainder; FIX reuses the same unit to add D back.
    assign w_add_a   = (r_state == RUN) ? w_p_shift : r_p;
    assign w_add_sub = (r_state == RUN) && !r_p[PW-1];

    addsub18 #(
        .W(PW)
    ) u_addsub (
        .i_a  (w_add_a),
        .i_b  ({{(PW-VW){1'b0}}, r_d}),
        .i_sub(w_add_sub),
        .o_y  (w_sum)
    );

    // NOTE: every path assigns a default first, so the next-state decode
    // cannot infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = (divisor == '0) ? DONE : RUN;
            RUN:  if (r_cnt == '0) w_state_nxt = FIX;
            FIX:  w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_d   <= divisor;
                        r_p   <= '0;
                        r_q   <= dividend;
                        r_cnt <= CW'(DW - 1);
                        if (divisor == '0) begin
                            r_quotient  <= DZ_QUOT;
                            r_remainder <= '0;
                            r_div_zero  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_p <= w_sum;
                    r_q <= {r_q[DW-2:0], ~w_sum[PW-1]};
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_quotient  <= r_q;
                    r_remainder <= r_p[PW-1] ? w_sum[VW-1:0] : r_p[VW-1:0];
                    r_div_zero  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule
